dino_input_conditioner: RTL and testbench



---
 rtl/dino_input_conditioner.sv | 135 +++++++++++++
 tb/tb_dino_input_conditioner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dino_input_conditioner.sv
// Button conditioning for the Dino game core: sync + debounce per button,
// plus frame-aligned jump request with req/ack handshake and press counter.
module dino_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       up_raw,
  input  logic       down_raw,
  input  logic       frame_tick,
  input  logic       jump_ack,
  output logic       jump_req,
  output logic       duck,
  output logic       up_db,
  output logic       down_db,
  output logic [7:0] press_count
);

  localparam int unsigned N_CH = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} db_state_t;

  logic [N_CH-1:0] raw_vec;
  logic [N_CH-1:0] db;
  logic            up_rise_c;
  logic            capture_c;
  logic            launch_c;
  logic            jump_pending;

  assign raw_vec = {down_raw, up_raw};
  assign up_db   = db[0];
  assign down_db = db[1];

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    db_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;
    logic             db_q;

    // Two-flop synchronizer followed by the stability-counting debounce FSM
    always_ff @(posedge clk) begin
      if (reset) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        state <= LOW;
        cnt   <= '0;
        db_q  <= 1'b0;
      end else begin
        s1 <= raw_vec[g];
        s2 <= s1;
        case (state)
          LOW: begin
            if (s2) begin
              state <= RISE_CHK;
              cnt   <= CNT_W'(1);
            end
          end
          RISE_CHK: begin
            if (!s2) begin
              state <= LOW;
              cnt   <= '0;
            end else if (cnt == LAST_CNT) begin
              state <= HIGH;
              db_q  <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          HIGH: begin
            if (!s2) begin
              state <= FALL_CHK;
              cnt   <= CNT_W'(1);
            end
          end
          FALL_CHK: begin
            if (s2) begin
              state <= HIGH;
              cnt   <= '0;
            end else if (cnt == LAST_CNT) begin
              state <= LOW;
              db_q  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= LOW;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign db[g] = db_q;

    // The jump path captures on the same edge the debounced level rises
    if (g == 0) begin : g_rise
      assign up_rise_c = (state == RISE_CHK) && s2 && (cnt == LAST_CNT);
    end
  end

  // An ack arriving on the capture edge frees the request slot for that capture
  assign capture_c = up_rise_c && !jump_pending && (!jump_req || jump_ack);
  // A request never relaunches on the tick that shares its ack edge
  assign launch_c  = frame_tick && jump_pending && !jump_req;

  // Jump capture/launch/ack handshake, press counter and duck gating
  always_ff @(posedge clk) begin
    if (reset) begin
      jump_pending <= 1'b0;
      jump_req     <= 1'b0;
      press_count  <= 8'd0;
      duck         <= 1'b0;
    end else begin
      duck <= db[1] & ~db[0];
      if (capture_c) begin
        jump_pending <= 1'b1;
        press_count  <= press_count + 8'd1;
      end else if (launch_c) begin
        jump_pending <= 1'b0;
      end
      if (jump_req && jump_ack) begin
        jump_req <= 1'b0;
      end else if (launch_c) begin
        jump_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dino_input_conditioner.sv
// Self-checking bench for dino_input_conditioner with a behavioural model.
module tb_dino_input_conditioner;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       up_raw;
  logic       down_raw;
  logic       frame_tick;
  logic       jump_ack;
  logic       jump_req;
  logic       duck;
  logic       up_db;
  logic       down_db;
  logic [7:0] press_count;

  int checks   = 0;
  int failures = 0;

  // Reference state: raw-sample delay lines, debounced levels, handshake
  bit hq_up[$];
  bit hq_dn[$];
  bit m_up_db, m_dn_db;
  int run_up, run_dn;
  bit m_pend, m_req, m_duck;
  int m_press;

  dino_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .up_raw      (up_raw),
    .down_raw    (down_raw),
    .frame_tick  (frame_tick),
    .jump_ack    (jump_ack),
    .jump_req    (jump_req),
    .duck        (duck),
    .up_db       (up_db),
    .down_db     (down_db),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Level flips once D consecutive samples disagree with it
  task automatic deb(input bit s, inout bit db, inout int run, output bit rose);
    rose = 1'b0;
    if (s != db) begin
      run++;
      if (run == int'(D)) begin
        db   = s;
        run  = 0;
        rose = s;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_edge();
    bit su, sd, ou, od, rise, rdn, cap, launch;
    if (reset) begin
      hq_up = '{1'b0, 1'b0};
      hq_dn = '{1'b0, 1'b0};
      m_up_db = 0; m_dn_db = 0; run_up = 0; run_dn = 0;
      m_pend = 0; m_req = 0; m_duck = 0; m_press = 0;
      return;
    end
    hq_up.push_back(up_raw);
    hq_dn.push_back(down_raw);
    su = hq_up.pop_front();
    sd = hq_dn.pop_front();
    ou = m_up_db;
    od = m_dn_db;
    deb(su, m_up_db, run_up, rise);
    deb(sd, m_dn_db, run_dn, rdn);
    cap    = rise && !m_pend && (!m_req || jump_ack);
    launch = frame_tick && m_pend && !m_req;
    if (cap) begin
      m_pend  = 1;
      m_press = (m_press + 1) % 256;
    end else if (launch) begin
      m_pend = 0;
    end
    if (m_req && jump_ack) m_req = 0;
    else if (launch)       m_req = 1;
    m_duck = od & ~ou;
  endtask

  // One clock: drive, let the edge happen, update model, compare away from edge
  task automatic cycle(input bit r, input bit u, input bit d, input bit t, input bit a);
    reset = r; up_raw = u; down_raw = d; frame_tick = t; jump_ack = a;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("jump_req", 32'(jump_req), 32'(m_req));
    check("duck", 32'(duck), 32'(m_duck));
    check("up_db", 32'(up_db), 32'(m_up_db));
    check("down_db", 32'(down_db), 32'(m_dn_db));
    check("press_count", 32'(press_count), 32'(m_press));
  endtask

  task automatic hold(input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) cycle(0, u, d, 0, 0);
  endtask

  initial begin
    bit bseq[7];
    int hu, hd;
    bit cu, cd;
    bseq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held two cycles
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_jump_req", 32'(jump_req), 0);
    check("rst_press", 32'(press_count), 0);

    // Clean step: db at edge 6, tick at 10, ack at 14
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 1, 0, i == 10, i == 14);
      if (i == 5)  check("step_up_db_e5", 32'(up_db), 0);
      if (i == 6)  check("step_up_db_e6", 32'(up_db), 1);
      if (i == 9)  check("step_req_e9", 32'(jump_req), 0);
      if (i == 10) check("step_req_e10", 32'(jump_req), 1);
      if (i == 13) check("step_req_e13", 32'(jump_req), 1);
      if (i == 14) check("step_req_e14", 32'(jump_req), 0);
    end
    check("step_press", 32'(press_count), 1);
    hold(0, 0, 8);

    // Bounce then settle: exactly one capture
    for (int i = 0; i < 7; i++) begin
      cycle(0, bseq[i], 0, 0, 0);
      check("bounce_no_db", 32'(up_db), 0);
    end
    hold(1, 0, 10);
    check("bounce_press", 32'(press_count), 2);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 1);
    hold(0, 0, 8);

    // Second press while a request is outstanding is dropped
    hold(1, 0, 8);
    cycle(0, 1, 0, 1, 0);
    check("outst_req", 32'(jump_req), 1);
    hold(0, 0, 8);
    hold(1, 0, 8);
    check("outst_press", 32'(press_count), 3);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 1, 0);
    check("outst_no_spurious", 32'(jump_req), 0);
    hold(0, 0, 8);

    // Duck gating by up
    hold(0, 1, 8);
    check("duck_on", 32'(duck), 1);
    hold(1, 1, 8);
    check("duck_sup", 32'(duck), 0);
    hold(0, 1, 8);
    check("duck_back", 32'(duck), 1);
    cycle(0, 0, 1, 1, 0);
    cycle(0, 0, 1, 0, 1);
    hold(0, 0, 8);

    // Reset mid-operation: outstanding request and pending capture both cleared
    hold(1, 0, 8);
    cycle(0, 1, 0, 1, 0);
    check("pre_rst_req", 32'(jump_req), 1);
    cycle(1, 1, 0, 0, 0);
    check("mid_rst_req", 32'(jump_req), 0);
    check("mid_rst_press", 32'(press_count), 0);
    hold(0, 0, 8);
    hold(1, 0, 8);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("rst_pend_cleared", 32'(jump_req), 0);
    hold(0, 0, 8);

    // Randomized bouncing buttons, ticks and acks against the model
    hu = 0; hd = 0; cu = 0; cd = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hu == 0) begin cu = 1'($urandom_range(0, 1)); hu = int'($urandom_range(1, 9)); end
      if (hd == 0) begin cd = 1'($urandom_range(0, 1)); hd = int'($urandom_range(1, 9)); end
      cycle(0, cu, cd, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
      hu--; hd--;
    end

    // 256 accepted presses wrap the counter
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 256; k++) begin
      hold(1, 0, 7);
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1);
      hold(0, 0, 6);
      if (k == 254) check("wrap_255", 32'(press_count), 255);
    end
    check("wrap_0", 32'(press_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
